// File: rtl/irq_ctrl_pkg.sv
// Purpose: shared constants for irq_ctrl (OCW command codes, ack FSM states,
//          implemented-bit mask helper).
// Latency: n/a (declarations only).  Backpressure: n/a.
package irq_ctrl_pkg;

  // OCW command codes written to IO_BASE+0
  localparam logic [7:0] OCW_EOI        = 8'h20;  // clear highest-priority ISR bit
  localparam logic [7:0] OCW_SEOI       = 8'h60;  // 8'h60|k clears ISR[k]
  localparam logic [7:0] OCW_SEOI_MASK  = 8'hF8;  // compare bits [7:3] only
  localparam logic [7:0] OCW_RD_IRR     = 8'h0A;  // IO_BASE+0 reads return IRR
  localparam logic [7:0] OCW_RD_ISR     = 8'h0B;  // IO_BASE+0 reads return ISR

  // Interrupt-acknowledge FSM encodings
  localparam logic ST_IDLE = 1'b0;  // waiting for the first INTA cycle
  localparam logic ST_ACK1 = 1'b1;  // first INTA seen, vector goes out on the next

  // Index returned when an INTA arrives with nothing qualifying
  localparam logic [2:0] SPURIOUS_IDX = 3'd7;

  // Ones in the bit positions that correspond to real IRQ inputs
  function automatic logic [7:0] impl_mask(input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_prio.sv
// Purpose: fixed-priority resolver, lowest set index wins.
// Latency: combinational.  Backpressure: none.
// Ports: req_i request vector in; idx_o winning index; vld_o any bit set.
module irq_prio (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       vld_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = 3'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Purpose: 8259-style interrupt controller, fixed priority, two-cycle INTA vector.
// Latency: iIrq edge -> oInt 4 clocks (2 sync + IRR + oInt flops); reads/vector combinational.
// Backpressure: none; strobes are single-cycle and always accepted.
// Ports: iClk/iRst (sync, active high); iIrq async requests; iAddr/iData/iIoWr/iIoRd
//        CPU I/O bus; iIntAck INTA pulses; oInt request to CPU; oSel/oData read bus.
// Option: define IRQ_CTRL_LEVEL_EN to make IRR follow the synchronised request level.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ  = 8,
  parameter logic [7:0]  VEC_BASE = 8'h08,
  parameter logic [15:0] IO_BASE  = 16'h0020
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [NUM_IRQ-1:0] iIrq,
  input  logic [19:0]        iAddr,
  input  logic [7:0]         iData,
  input  logic               iIoWr,
  input  logic               iIoRd,
  input  logic               iIntAck,
  output logic               oInt,
  output logic               oSel,
  output logic [7:0]         oData
);

  localparam logic [7:0] IMPL = impl_mask(NUM_IRQ);

  // Only the low 16 address bits take part in I/O decode.
  logic unused_addr;
  assign unused_addr = ^iAddr[19:16];

  // ---------------- state ----------------
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [7:0]         irr_q, irr_d;
  logic [7:0]         isr_q, isr_d;
  logic [7:0]         imr_q, imr_d;
  logic               rdsel_q, rdsel_d;   // 0: IRR, 1: ISR
  logic               state_q, state_d;
  logic [2:0]         vec_idx_q, vec_idx_d;
  logic               int_q, int_d;

  // ---------------- synchroniser view ----------------
  logic [7:0] sync_lvl;
  always_comb begin
    sync_lvl = '0;
    sync_lvl[NUM_IRQ-1:0] = sync2_q;
  end

  assign sync1_d = iIrq;
  assign sync2_d = sync1_q;

`ifndef IRQ_CTRL_LEVEL_EN
  // Third flop only remembers the previous synchronised level for edge detect.
  logic [NUM_IRQ-1:0] sync3_q;
  logic [7:0]         sync_rise;
  always_comb begin
    sync_rise = '0;
    sync_rise[NUM_IRQ-1:0] = sync2_q & ~sync3_q;
  end
  always_ff @(posedge iClk) begin
    if (iRst) sync3_q <= '0;
    else      sync3_q <= sync2_q;
  end
`endif

  // ---------------- address decode ----------------
  logic sel_cmd, sel_imr;
  logic wr_cmd, wr_imr, rd_cmd, rd_imr;
  assign sel_cmd = (iAddr[15:0] == IO_BASE);
  assign sel_imr = (iAddr[15:0] == IO_BASE + 16'd1);
  assign wr_cmd  = iIoWr & sel_cmd;
  assign wr_imr  = iIoWr & sel_imr;
  assign rd_cmd  = iIoRd & sel_cmd;
  assign rd_imr  = iIoRd & sel_imr;

  // ---------------- priority ----------------
  logic [7:0] req_vec;
  logic [2:0] req_idx, isr_idx;
  logic       req_vld, isr_vld;
  logic       qualify;

  assign req_vec = irr_q & ~imr_q & IMPL;

  irq_prio u_req_prio (
    .req_i (req_vec),
    .idx_o (req_idx),
    .vld_o (req_vld)
  );

  irq_prio u_isr_prio (
    .req_i (isr_q),
    .idx_o (isr_idx),
    .vld_o (isr_vld)
  );

  // A request only interrupts if it strictly outranks everything in service.
  assign qualify = req_vld & (~isr_vld | (req_idx < isr_idx));

  // ---------------- ack FSM ----------------
  logic       ack_first, ack_second, ack_take;
  logic [7:0] ack_bit;

  assign ack_first  = iIntAck & (state_q == ST_IDLE);
  assign ack_second = iIntAck & (state_q == ST_ACK1);
  assign ack_take   = ack_first & qualify;
  assign ack_bit    = ack_take ? (8'h01 << req_idx) : 8'h00;

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    if (ack_first) begin
      state_d   = ST_ACK1;
      vec_idx_d = ack_take ? req_idx : SPURIOUS_IDX;
    end else if (ack_second) begin
      state_d   = ST_IDLE;
    end
  end

  // ---------------- OCW / EOI ----------------
  logic [7:0] eoi_clr;
  always_comb begin
    eoi_clr = '0;
    rdsel_d = rdsel_q;
    if (wr_cmd) begin
      if (iData == OCW_EOI) begin
        if (isr_vld) eoi_clr = 8'h01 << isr_idx;
      end else if ((iData & OCW_SEOI_MASK) == OCW_SEOI) begin
        eoi_clr = (8'h01 << iData[2:0]) & IMPL;
      end else if (iData == OCW_RD_IRR) begin
        rdsel_d = 1'b0;
      end else if (iData == OCW_RD_ISR) begin
        rdsel_d = 1'b1;
      end
    end
  end

  // ---------------- next state ----------------
  // EOI clears first so an ack's ISR set in the same clock survives.
  assign isr_d = ((isr_q & ~eoi_clr) | ack_bit) & IMPL;

`ifdef IRQ_CTRL_LEVEL_EN
  assign irr_d = sync_lvl & IMPL;
`else
  // A fresh edge beats the ack clear on the same bit.
  assign irr_d = ((irr_q & ~ack_bit) | sync_rise) & IMPL;
`endif

  assign imr_d = wr_imr ? (iData | ~IMPL) : imr_q;
  assign int_d = qualify & ~ack_first;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      imr_q     <= 8'hFF;
      rdsel_q   <= 1'b0;
      state_q   <= ST_IDLE;
      vec_idx_q <= '0;
      int_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      rdsel_q   <= rdsel_d;
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      int_q     <= int_d;
    end
  end

  assign oInt = int_q;

  // ---------------- read bus ----------------
  // Vector output takes precedence over a simultaneous register read.
  always_comb begin
    oSel  = 1'b0;
    oData = 8'h00;
    if (!iRst) begin
      if (ack_second) begin
        oSel  = 1'b1;
        oData = {VEC_BASE[7:3], vec_idx_q};
      end else if (rd_cmd) begin
        oSel  = 1'b1;
        oData = rdsel_q ? isr_q : irr_q;
      end else if (rd_imr) begin
        oSel  = 1'b1;
        oData = imr_q;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  localparam logic [15:0] BASE = 16'h0020;
  localparam logic [7:0]  VEC  = 8'h08;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [7:0]  iIrq = '0;
  logic [19:0] iAddr = '0;
  logic [7:0]  iData = '0;
  logic        iIoWr = 1'b0;
  logic        iIoRd = 1'b0;
  logic        iIntAck = 1'b0;
  logic        oInt, oSel;
  logic [7:0]  oData;

  irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(VEC), .IO_BASE(BASE)) dut (
    .iClk(iClk), .iRst(iRst), .iIrq(iIrq), .iAddr(iAddr), .iData(iData),
    .iIoWr(iIoWr), .iIoRd(iIoRd), .iIntAck(iIntAck),
    .oInt(oInt), .oSel(oSel), .oData(oData)
  );

  always #50 iClk = ~iClk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_s1 = '0, m_s2 = '0, m_s3 = '0;
  logic [7:0] m_irr = '0, m_isr = '0, m_imr = 8'hFF;
  bit         m_rd_isr = 0, m_pend = 0, m_int = 0;
  int         m_n = 0;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  always @(posedge iClk) begin : model
    logic [7:0] aclr, eclr;
    int hr, hs;
    bit qual;
    if (iRst) begin
      m_s1 = '0; m_s2 = '0; m_s3 = '0;
      m_irr = '0; m_isr = '0; m_imr = 8'hFF;
      m_rd_isr = 0; m_pend = 0; m_int = 0; m_n = 0;
    end else begin
      hr = lowest(m_irr & ~m_imr);
      hs = lowest(m_isr);
      qual = (hr < 8) && (hr < hs);
      aclr = '0;
      eclr = '0;
      m_int = qual && !(iIntAck && !m_pend);
      if (iIntAck) begin
        if (!m_pend) begin
          if (qual) begin m_n = hr; aclr[hr] = 1'b1; end
          else m_n = 7;
          m_pend = 1;
        end else begin
          m_pend = 0;
        end
      end
      if (iIoWr && iAddr[15:0] == BASE) begin
        if (iData == 8'h20) begin
          if (hs < 8) eclr[hs] = 1'b1;
        end else if (iData >= 8'h60 && iData <= 8'h67) eclr[iData - 8'h60] = 1'b1;
        else if (iData == 8'h0A) m_rd_isr = 0;
        else if (iData == 8'h0B) m_rd_isr = 1;
      end
      if (iIoWr && iAddr[15:0] == BASE + 16'd1) m_imr = iData;
      m_isr = (m_isr & ~eclr) | aclr;
`ifdef IRQ_CTRL_LEVEL_EN
      m_irr = m_s2;
`else
      m_irr = (m_irr & ~aclr) | (m_s2 & ~m_s3);
`endif
      m_s3 = m_s2;
      m_s2 = m_s1;
      m_s1 = iIrq;
    end
  end

  always @(negedge iClk) begin : compare
    logic       es;
    logic [7:0] ed;
    if (chk_en) begin
      es = 1'b0;
      ed = 8'h00;
      if (!iRst) begin
        if (iIntAck && m_pend) begin es = 1'b1; ed = (VEC & 8'hF8) + 8'(m_n); end
        else if (iIoRd && iAddr[15:0] == BASE) begin es = 1'b1; ed = m_rd_isr ? m_isr : m_irr; end
        else if (iIoRd && iAddr[15:0] == BASE + 16'd1) begin es = 1'b1; ed = m_imr; end
      end
      check("model_oInt", {7'b0, oInt}, {7'b0, m_int});
      check("model_oSel", {7'b0, oSel}, {7'b0, es});
      check("model_oData", oData, ed);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge iClk); #1;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    iAddr = {4'h0, a}; iData = d; iIoWr = 1'b1;
    tick();
    iIoWr = 1'b0;
  endtask

  task automatic io_rd(input logic [15:0] a, output logic [7:0] v, output logic s);
    iAddr = {4'h0, a}; iIoRd = 1'b1;
    @(negedge iClk);
    v = oData; s = oSel;
    tick();
    iIoRd = 1'b0;
  endtask

  task automatic inta(output logic [7:0] v, output logic s);
    iIntAck = 1'b1;
    @(negedge iClk);
    v = oData; s = oSel;
    tick();
    iIntAck = 1'b0;
  endtask

  task automatic wait_int(input int maxc, input string name);
    for (int k = 0; k < maxc; k++) begin
      if (oInt) break;
      tick();
    end
    check(name, {7'b0, oInt}, 8'h01);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    iIrq = m;
    tick(); tick();
    iIrq = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] v;
    logic s;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    iRst = 1'b0;

    // reset state
    check("rst_oInt", {7'b0, oInt}, 8'h00);
    io_rd(BASE + 16'd1, v, s); check("rst_imr", v, 8'hFF); check("rst_imr_sel", {7'b0, s}, 8'h01);
    io_rd(BASE, v, s);         check("rst_irr", v, 8'h00);

    // IRQ0 alone, latency and vector
    io_wr(BASE + 16'd1, 8'hFE);
    iIrq = 8'h01;
    wait_int(4, "irq0_int_within_4");
    iIrq = '0;
    inta(v, s); check("irq0_ack1_sel", {7'b0, s}, 8'h00);
    inta(v, s); check("irq0_vec", v, 8'h08); check("irq0_vec_sel", {7'b0, s}, 8'h01);
    check("irq0_int_dropped", {7'b0, oInt}, 8'h00);
    io_wr(BASE, 8'h0B);
    io_rd(BASE, v, s); check("irq0_isr", v, 8'h01);
    io_wr(BASE, 8'h20);
    io_rd(BASE, v, s); check("irq0_isr_after_eoi", v, 8'h00);
    io_wr(BASE, 8'h0A);

    // IRQ1 and IRQ3 together, EOI then next
    io_wr(BASE + 16'd1, 8'h00);
    pulse_irq(8'h0A);
    wait_int(6, "irq13_int");
    inta(v, s); inta(v, s); check("irq13_first_vec", v, 8'h09);
    io_wr(BASE, 8'h20);
    wait_int(4, "irq3_int_after_eoi");
    inta(v, s); inta(v, s); check("irq13_second_vec", v, 8'h0B);
    io_wr(BASE, 8'h20);

    // IRQ2 in service blocks IRQ5 until specific EOI
    pulse_irq(8'h04);
    wait_int(6, "irq2_int");
    inta(v, s); inta(v, s); check("irq2_vec", v, 8'h0A);
    pulse_irq(8'h20);
    repeat (6) tick();
    check("irq5_blocked", {7'b0, oInt}, 8'h00);
    io_wr(BASE, 8'h62);
    wait_int(3, "irq5_int_after_seoi");
    inta(v, s); inta(v, s); check("irq5_vec", v, 8'h0D);
    io_wr(BASE, 8'h20);

    // spurious acknowledge
    inta(v, s); inta(v, s); check("spurious_vec", v, 8'h0F);
    io_rd(BASE, v, s); check("spurious_irr", v, 8'h00);
    io_wr(BASE, 8'h0B);
    io_rd(BASE, v, s); check("spurious_isr", v, 8'h00);
    io_wr(BASE, 8'h0A);

    // IMR readback
    io_wr(BASE + 16'd1, 8'h5A);
    io_rd(BASE + 16'd1, v, s); check("imr_5a", v, 8'h5A);

    // reset between INTA cycles
    io_wr(BASE + 16'd1, 8'h00);
    pulse_irq(8'h10);
    wait_int(6, "irq4_int");
    inta(v, s);
    iRst = 1'b1; tick(); iRst = 1'b0;
    check("midack_rst_oInt", {7'b0, oInt}, 8'h00);
    io_rd(BASE, v, s);         check("midack_rst_irr", v, 8'h00);
    io_rd(BASE + 16'd1, v, s); check("midack_rst_imr", v, 8'hFF);
    inta(v, s); check("postrst_first_ack_sel", {7'b0, s}, 8'h00);
    inta(v, s); check("postrst_vec", v, 8'h0F);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [7:0] d;
      int r, a;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) iIrq[b] = ~iIrq[b];
      iIoWr = 1'b0; iIoRd = 1'b0; iIntAck = 1'b0;
      iRst = ($urandom_range(0, 149) == 0);
      a = $urandom_range(0, 3);
      case (a)
        0: iAddr = {4'($urandom), BASE};
        1: iAddr = {4'($urandom), BASE + 16'd1};
        2: iAddr = {4'($urandom), BASE + 16'd2};
        default: iAddr = 20'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: d = 8'h20;
        1: d = 8'h60 + 8'($urandom_range(0, 7));
        2: d = 8'h0A;
        3: d = 8'h0B;
        default: d = 8'($urandom);
      endcase
      if (a == 1 && $urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 31));
      iData = d;
      r = $urandom_range(0, 9);
      if (r < 2) iIoWr = 1'b1;
      else if (r < 4) iIoRd = 1'b1;
      else if (r < 6) iIntAck = 1'b1;
      tick();
    end
    iIoWr = 1'b0; iIoRd = 1'b0; iIntAck = 1'b0; iRst = 1'b0; iIrq = '0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
